legv8_multicycle_ctrl: RTL and testbench
========================================

# legv8_multicycle_ctrl

Multi-cycle control FSM for the LEGv8 core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back, and drives every datapath select:
- the 5-bit register-address mux (Reg2Loc);
- the 64-bit ALU-B mux (ALUSrc);
- the write-back mux (MemtoReg);
- the PC mux (PCSrc).

It also drives register-file and IR/PC write enables and request/acknowledge handshakes to instruction and data memory.

## Interface
Parameters: none (encodings fixed in the package).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- opcode  in  11  IR[31:21], stable from cycle after ir_write
- zero  in  1  ALU zero flag, sampled only in BRANCH
- imem_ack  in  1  instruction memory done; meaningful only while imem_req=1
- dmem_ack  in  1  data memory done; meaningful only while dmem_req=1
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  1=store, 0=load (valid with dmem_req)
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  1  PC mux select: 0=PC+4, 1=branch target
- reg2loc  out  1  1=second read address from Rt[4:0]
- alu_src  out  1  1=ALU-B from sign-extended immediate
- alu_op  out  2  00 add, 01 pass-B, 10 R-type funct
- mem_to_reg  out  1  1=write-back from load data
- reg_write  out  1  register-file write enable
- retire  out  1  one-cycle pulse, instruction complete
- trap  out  1  sticky, illegal opcode seen

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_MEM, MEM_RD, MEM_WR, WB_R, WB_LD, BRANCH, TRAP.
- Opcode classes, decoded in DECODE and latched in an internal class register; opcode is ignored elsewhere:
  - R: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR
  - LD: 11111000010 LDUR
  - ST: 11111000000 STUR
  - CBZ: opcode[10:3]=10110100
  - B: opcode[10:5]=000101
  - anything else is illegal
- Transitions:
  - FETCH→DECODE on imem_ack, else stay.
  - DECODE→EXEC_R (R), EXEC_MEM (LD/ST), BRANCH (CBZ/B), TRAP (illegal).
  - EXEC_R→WB_R.
  - EXEC_MEM→MEM_RD (LD) or MEM_WR (ST).
  - MEM_RD→WB_LD on dmem_ack, else stay.
  - MEM_WR→FETCH on dmem_ack, else stay.
  - WB_R, WB_LD and BRANCH→FETCH.
  - TRAP→TRAP until reset.
- Outputs are Moore from state, except where gated by ack or zero:
  - FETCH: imem_req=1; ir_write=imem_ack.
  - DECODE: reg2loc=1 if class ST or CBZ.
  - EXEC_R: alu_op=10.
  - EXEC_MEM: alu_src=1, alu_op=00; reg2loc=1 if ST.
  - MEM_RD: dmem_req=1, dmem_we=0.
  - MEM_WR: dmem_req=1, dmem_we=1, reg2loc=1; pc_write=retire=dmem_ack.
  - WB_R: reg_write=1, pc_write=1, retire=1, alu_op=10.
  - WB_LD: reg_write=1, mem_to_reg=1, pc_write=1, retire=1.
  - BRANCH: alu_op=01, reg2loc=1; pc_write=1, retire=1; pc_src = (class B) | (class CBZ & zero).
  - TRAP: trap=1, all else 0.
- Every output not listed for a state is 0. pc_src is 0 in every state except BRANCH.

## Timing
- Reset: state=FETCH. During and right after reset, imem_req=1 and every other output is 0 (ir_write follows imem_ack). Class register and trap cleared.
- Latency in cycles from FETCH entry, with ack in the entry cycle: R=4, LD=5, ST=4, CBZ/B=3. Each cycle an ack is withheld adds one cycle.
- Handshakes:
  - req rises on state entry and holds until ack.
  - ack may arrive in the same cycle req rises.
  - ack with req=0 is ignored.
  - No request is issued twice for one access.
- Reset mid-access (any state, including TRAP): next cycle is FETCH. dmem_req drops in the reset cycle's successor. No pc_write, reg_write or retire is produced for the aborted instruction.
- reset has priority over ack in the same cycle.

## Structure
- Package legv8_ctrl_pkg holds:
  - state enum encodings (4 bits);
  - class encodings (3 bits: R, LD, ST, CBZ, B, ILL);
  - opcode constants and alu_op codes.
- Sub-module legv8_opdecode: combinational opcode(11)→class(3). It is instantiated once and feeds the class register in DECODE.
- The top level holds the state register, class register and output decode.

## Test plan
- Reset, then ADD (10001011000) with imem_ack tied 1 → states FETCH, DECODE, EXEC_R, WB_R. reg_write=1 and pc_write=1 in cycle 4, pc_src=0, retire once.
- LDUR with dmem_ack delayed 2 cycles → MEM_RD held 3 cycles with dmem_req=1, dmem_we=0. Then WB_LD with mem_to_reg=1 and reg_write=1. Total 7 cycles.
- STUR with ack in the first MEM_WR cycle → dmem_we=1 and reg2loc=1, pc_write=retire=1 in cycle 4. reg_write stays 0 throughout.
- CBZ (opcode 10110100101) with zero=1 → pc_src=1 in BRANCH. Repeat with zero=0 → pc_src=0. Both take 3 cycles.
- Illegal opcode 00000000000 → TRAP on cycle 3 and trap=1 held for 20 cycles with imem_req=0. Then reset → FETCH, trap=0.
- Reset asserted during MEM_RD (dmem_ack=0) → next cycle is FETCH, dmem_req=0, no retire or reg_write. A following B instruction executes with pc_src=1.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// legv8_ctrl_pkg : state/class encodings and opcode constants   (rev 1.0)
// ============================================================================
package legv8_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_MEM = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_WB_R     = 4'd6,
      ST_WB_LD    = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_TRAP     = 4'd9
   } state_t;

   // ILL is the all-zero code so a cleared class register reads as illegal.
   typedef enum logic [2:0] {
      CLS_ILL = 3'd0,
      CLS_R   = 3'd1,
      CLS_LD  = 3'd2,
      CLS_ST  = 3'd3,
      CLS_CBZ = 3'd4,
      CLS_B   = 3'd5
   } iclass_t;

   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
   localparam logic [5:0]  OP_B_PFX   = 6'b000101;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_PASSB = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/legv8_opdecode.sv
`default_nettype none
// ============================================================================
// legv8_opdecode : combinational opcode -> instruction class    (rev 1.0)
// ============================================================================
module legv8_opdecode
   import legv8_ctrl_pkg::*;
(
   input  logic [10:0] opcode,
   output iclass_t     iclass
);

   always_comb begin
      iclass = CLS_ILL;
      if (opcode == OP_ADD || opcode == OP_SUB ||
          opcode == OP_AND || opcode == OP_ORR)
         iclass = CLS_R;
      else if (opcode == OP_LDUR)
         iclass = CLS_LD;
      else if (opcode == OP_STUR)
         iclass = CLS_ST;
      else if (opcode[10:3] == OP_CBZ_PFX)
         iclass = CLS_CBZ;
      else if (opcode[10:5] == OP_B_PFX)
         iclass = CLS_B;
   end

endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// legv8_multicycle_ctrl : multi-cycle LEGv8 control FSM         (rev 1.0)
// ============================================================================
module legv8_multicycle_ctrl
   import legv8_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg2loc,
   output logic        alu_src,
   output logic [1:0]  alu_op,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        retire,
   output logic        trap
);

   state_t  state, next_state;
   iclass_t cls, dec_cls;

   legv8_opdecode u_opdecode (
      .opcode (opcode),
      .iclass (dec_cls)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_FETCH;
         cls   <= CLS_ILL;
      end else begin
         state <= next_state;
         if (state == ST_DECODE)
            cls <= dec_cls;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH:    if (imem_ack) next_state = ST_DECODE;
         ST_DECODE: begin
            case (dec_cls)
               CLS_R:          next_state = ST_EXEC_R;
               CLS_LD, CLS_ST: next_state = ST_EXEC_MEM;
               CLS_CBZ, CLS_B: next_state = ST_BRANCH;
               default:        next_state = ST_TRAP;
            endcase
         end
         ST_EXEC_R:   next_state = ST_WB_R;
         ST_EXEC_MEM: next_state = (cls == CLS_ST) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD:   if (dmem_ack) next_state = ST_WB_LD;
         ST_MEM_WR:   if (dmem_ack) next_state = ST_FETCH;
         ST_WB_R, ST_WB_LD, ST_BRANCH: next_state = ST_FETCH;
         ST_TRAP:     next_state = ST_TRAP;
         default:     next_state = ST_FETCH;
      endcase
   end

   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      trap       = 1'b0;
      case (state)
         ST_FETCH: begin
            imem_req = 1'b1;
            ir_write = imem_ack;
         end
         // Class register is loaded at the end of DECODE, so use the live decode here.
         ST_DECODE:   reg2loc = (dec_cls == CLS_ST) || (dec_cls == CLS_CBZ);
         ST_EXEC_R:   alu_op  = ALU_FUNCT;
         ST_EXEC_MEM: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
            reg2loc = (cls == CLS_ST);
         end
         ST_MEM_RD:   dmem_req = 1'b1;
         ST_MEM_WR: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            reg2loc  = 1'b1;
            pc_write = dmem_ack;
            retire   = dmem_ack;
         end
         ST_WB_R: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            retire    = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         ST_WB_LD: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            pc_write   = 1'b1;
            retire     = 1'b1;
         end
         ST_BRANCH: begin
            alu_op   = ALU_PASSB;
            reg2loc  = 1'b1;
            pc_write = 1'b1;
            retire   = 1'b1;
            pc_src   = (cls == CLS_B) || ((cls == CLS_CBZ) && zero);
         end
         ST_TRAP:     trap = 1'b1;
         default: ;
      endcase
      // An instruction aborted by reset must not commit architectural state.
      if (reset) begin
         pc_write  = 1'b0;
         reg_write = 1'b0;
         retire    = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_legv8_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_legv8_multicycle_ctrl : randomized bench with per-cycle expected outputs
// ============================================================================
module tb_legv8_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        reset, zero, imem_ack, dmem_ack;
   logic [10:0] opcode;
   logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
   logic        reg2loc, alu_src, mem_to_reg, reg_write, retire, trap;
   logic [1:0]  alu_op;
   logic [15:0] obs;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   legv8_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
      .trap(trap)
   );

   assign obs = {2'b00, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                 reg2loc, alu_src, alu_op, mem_to_reg, reg_write, retire, trap};

   localparam logic [15:0] IREQ = 16'h2000, DREQ = 16'h1000, DWE  = 16'h0800,
                           IRW  = 16'h0400, PCW  = 16'h0200, PCS  = 16'h0100,
                           R2L  = 16'h0080, ASRC = 16'h0040, AOPF = 16'h0020,
                           AOPB = 16'h0010, M2R  = 16'h0008, RW   = 16'h0004,
                           RET  = 16'h0002, TRP  = 16'h0001;

   localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

   typedef struct {
      logic        ia, da, zr, rst;
      logic [10:0] op;
      logic [15:0] exp;
   } rec_t;

   rec_t q[$];
   int   n_instr = 0;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %04h expected %04h", tag, got, want);
   endtask

   function automatic int ref_class(input logic [10:0] op);
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000) return C_R;
      if (op == 11'b11111000010) return C_LD;
      if (op == 11'b11111000000) return C_ST;
      if (op[10:3] == 8'b10110100) return C_CBZ;
      if (op[10:5] == 6'b000101) return C_B;
      return C_ILL;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [10:0] rop();
      return 11'($urandom);
   endfunction

   task automatic push(input logic ia, input logic da, input logic zr,
                       input logic [10:0] op, input logic [15:0] e);
      rec_t r;
      r.ia = ia; r.da = da; r.zr = zr; r.rst = 1'b0; r.op = op; r.exp = e;
      q.push_back(r);
   endtask

   // Build the cycle-by-cycle expectation of one instruction, then play it.
   // Acks/zero/opcode are randomized wherever the controller must ignore them.
   task automatic run_instr(input string name, input logic [10:0] op, input logic z,
                            input int wi, input int wd, input int tc, input int abort_k);
      int c;
      c = ref_class(op);
      q.delete();
      for (int i = 0; i < wi; i++) push(1'b0, rb(), rb(), rop(), IREQ);
      push(1'b1, rb(), rb(), rop(), IREQ | IRW);
      push(rb(), rb(), rb(), op, (c == C_ST || c == C_CBZ) ? R2L : 16'h0000);
      case (c)
         C_R: begin
            push(rb(), rb(), rb(), rop(), AOPF);
            push(rb(), rb(), rb(), rop(), RW | PCW | RET | AOPF);
         end
         C_LD: begin
            push(rb(), rb(), rb(), rop(), ASRC);
            for (int i = 0; i < wd; i++) push(rb(), 1'b0, rb(), rop(), DREQ);
            push(rb(), 1'b1, rb(), rop(), DREQ);
            push(rb(), rb(), rb(), rop(), RW | M2R | PCW | RET);
         end
         C_ST: begin
            push(rb(), rb(), rb(), rop(), ASRC | R2L);
            for (int i = 0; i < wd; i++) push(rb(), 1'b0, rb(), rop(), DREQ | DWE | R2L);
            push(rb(), 1'b1, rb(), rop(), DREQ | DWE | R2L | PCW | RET);
         end
         C_CBZ, C_B: begin
            push(rb(), rb(), z, rop(),
                 AOPB | R2L | PCW | RET | ((c == C_B || z) ? PCS : 16'h0000));
         end
         default: begin
            for (int i = 0; i < tc; i++) push(rb(), rb(), rb(), rop(), TRP);
            push(rb(), rb(), rb(), rop(), TRP);
            q[q.size()-1].rst = 1'b1;
         end
      endcase
      if (abort_k >= 0 && abort_k < q.size()) begin
         q[abort_k].rst = 1'b1;
         q[abort_k].exp &= ~(PCW | RW | RET);
         while (q.size() > abort_k + 1) void'(q.pop_back());
      end
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         reset    = q[i].rst;
         imem_ack = q[i].ia;
         dmem_ack = q[i].da;
         zero     = q[i].zr;
         opcode   = q[i].op;
         #1 check_eq($sformatf("%s#%0d.cyc%0d", name, n_instr, i), obs, q[i].exp);
      end
      n_instr++;
   endtask

   initial begin
      logic [10:0] op;
      int          sel, ab;
      reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; opcode = '0;
      @(negedge clk);
      @(negedge clk);
      #1 check_eq("reset", obs, IREQ);

      run_instr("add",    11'b10001011000, 1'b0, 0, 0, 0, -1);
      run_instr("ldur",   11'b11111000010, 1'b0, 0, 2, 0, -1);
      run_instr("stur",   11'b11111000000, 1'b0, 0, 0, 0, -1);
      run_instr("cbz_z1", 11'b10110100101, 1'b1, 0, 0, 0, -1);
      run_instr("cbz_z0", 11'b10110100101, 1'b0, 0, 0, 0, -1);
      run_instr("ill",    11'b00000000000, 1'b0, 1, 0, 20, -1);
      run_instr("ld_abort", 11'b11111000010, 1'b0, 0, 3, 0, 3);
      run_instr("b",      11'b00010100111, 1'b0, 2, 0, 0, -1);

      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: op = 11'b10001011000;
            1: op = 11'b11001011000;
            2: op = 11'b10001010000;
            3: op = 11'b10101010000;
            4: op = 11'b11111000010;
            5: op = 11'b11111000000;
            6: op = {8'b10110100, 3'($urandom)};
            7: op = {6'b000101, 5'($urandom)};
            8: op = rop();
            default: op = 11'b00000000000;
         endcase
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
         run_instr("rnd", op, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(1, 5), ab);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
